// File: rtl/inta_sequencer.sv
// 8259-style interrupt acknowledge sequencer: request capture, priority resolution,
// two-pulse INTA handshake and the in-service register.
module inta_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic [4:0] vec_base,
  input  logic       aeoi,
  input  logic       init_done,
  input  logic       eoi,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] vec_out,
  output logic       vec_oe
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_e;

  state_e     state_q, state_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] ir_prev_q;
  logic       inta_prev_q;
  logic       int_out_q, int_out_d;
  logic       spur_q, spur_d;
  logic [2:0] sel_q, sel_d;

  logic [7:0] pend, ir_rise;
  logic [7:0] isr_set, isr_clr, irr_ack;
  logic [2:0] req_idx, ishi_idx;
  logic       inta_fall, inta_rise;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) r = 3'(i - 1);
    end
    return r;
  endfunction

  assign pend      = irr_q & ~imr;
  assign ir_rise   = ir & ~ir_prev_q;
  assign req_idx   = lowest(pend);
  assign ishi_idx  = lowest(isr_q);
  assign inta_fall = ~inta_n & inta_prev_q;
  assign inta_rise = inta_n & ~inta_prev_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    spur_d    = spur_q;
    int_out_d = 1'b0;
    isr_set   = '0;
    isr_clr   = '0;
    irr_ack   = '0;

    // EOI acts on the old ISR, so a bit set by a coincident acknowledge survives.
    if (eoi && (isr_q != '0)) isr_clr = 8'b1 << ishi_idx;

    if (!init_done) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (inta_fall) begin
            state_d = ACK1;
            spur_d  = (pend == '0);
            if (pend == '0) begin
              sel_d = 3'd7;
            end else begin
              sel_d   = req_idx;
              isr_set = 8'b1 << req_idx;
              if (!ltim) irr_ack = 8'b1 << req_idx;
            end
          end else begin
            int_out_d = (pend != '0) && ((isr_q == '0) || (req_idx < ishi_idx));
          end
        end
        ACK1: begin
          if (inta_fall) state_d = ACK2;
        end
        ACK2: begin
          if (inta_rise) begin
            state_d = IDLE;
            if (aeoi && !spur_q) isr_clr = isr_clr | (8'b1 << sel_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    isr_d = (isr_q & ~isr_clr) | isr_set;
    irr_d = ltim ? ir : ((irr_q & ~irr_ack) | ir_rise);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      irr_q       <= '0;
      isr_q       <= '0;
      ir_prev_q   <= '0;
      inta_prev_q <= 1'b1;
      int_out_q   <= 1'b0;
      spur_q      <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      ir_prev_q   <= ir;
      inta_prev_q <= inta_n;
      int_out_q   <= int_out_d;
      spur_q      <= spur_d;
      sel_q       <= sel_d;
    end
  end

  // Vector drive is combinational on inta_n so the bus is released as soon as the pulse ends.
  assign vec_oe  = (state_q == ACK2) && !inta_n;
  assign vec_out = vec_oe ? {vec_base, sel_q} : '0;
  assign int_out = int_out_q;
  assign irr     = irr_q;
  assign isr     = isr_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: expected vectors are queued when an
// acknowledge is started and compared when the DUT drives the vector.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic       ltim;
  logic [7:0] imr;
  logic [4:0] vec_base;
  logic       aeoi;
  logic       init_done;
  logic       eoi;
  logic       inta_n;
  logic       int_out;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] vec_out;
  logic       vec_oe;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];

  inta_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .ltim      (ltim),
    .imr       (imr),
    .vec_base  (vec_base),
    .aeoi      (aeoi),
    .init_done (init_done),
    .eoi       (eoi),
    .inta_n    (inta_n),
    .int_out   (int_out),
    .irr       (irr),
    .isr       (isr),
    .vec_out   (vec_out),
    .vec_oe    (vec_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the caller 2 time units after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic with_eoi);
    inta_n = 1'b0;
    eoi    = with_eoi;
    cyc(1);
    eoi    = 1'b0;
    cyc(1);
    inta_n = 1'b1;
    cyc(2);
  endtask

  task automatic raise(input logic [7:0] lines);
    ir = lines;
    cyc(1);
    ir = '0;
    cyc(1);
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    cyc(1);
    eoi = 1'b0;
  endtask

  // Vector monitor: one comparison per vec_oe assertion.
  initial begin
    logic seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (vec_oe && !seen) begin
        if (exp_q.size() == 0) check("vec_unexpected", {24'h0, vec_out}, 32'hFFFF_FFFF);
        else check("vec_out", {24'h0, vec_out}, {24'h0, exp_q.pop_front()});
      end
      seen = vec_oe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ir = '0; ltim = 1'b0; imr = '0; vec_base = 5'b01000;
    aeoi = 1'b0; init_done = 1'b0; eoi = 1'b0; inta_n = 1'b1;
    #1;
    check("rst_irr", irr, 0);
    check("rst_isr", isr, 0);
    check("rst_int", int_out, 0);
    check("rst_vec", vec_out, 0);
    check("rst_oe", vec_oe, 0);
    cyc(2);
    reset = 1'b0;
    init_done = 1'b1;
    cyc(1);

    // Single edge request on IR3
    ir = 8'h08;
    cyc(1);
    check("t1_irr", irr, 8'h08);
    check("t1_int_lat", int_out, 0);
    ir = '0;
    cyc(1);
    check("t1_int", int_out, 1);
    exp_q.push_back(8'h43);
    pulse(1'b0);
    check("t1_isr_ack1", isr, 8'h08);
    check("t1_irr_ack1", irr, 8'h00);
    check("t1_int_ack1", int_out, 0);
    pulse(1'b0);
    check("t1_isr", isr, 8'h08);
    check("t1_irr_end", irr, 8'h00);
    do_eoi();
    cyc(1);
    check("t1_isr_eoi", isr, 8'h00);

    // Simultaneous IR5 and IR2
    raise(8'h24);
    check("t2_int", int_out, 1);
    exp_q.push_back(8'h42);
    pulse(1'b0);
    pulse(1'b0);
    check("t2_isr", isr, 8'h04);
    check("t2_irr", irr, 8'h20);
    check("t2_int_blk", int_out, 0);
    do_eoi();
    cyc(1);
    check("t2_int_re", int_out, 1);
    exp_q.push_back(8'h45);
    pulse(1'b0);
    pulse(1'b0);
    check("t2_isr5", isr, 8'h20);
    check("t2_irr0", irr, 8'h00);
    do_eoi();
    cyc(1);

    // Nesting, plus EOI coinciding with a new ISR bit
    raise(8'h04);
    exp_q.push_back(8'h42);
    pulse(1'b0);
    pulse(1'b0);
    raise(8'h40);
    cyc(1);
    check("t3_irr6", irr, 8'h40);
    check("t3_int_low", int_out, 0);
    raise(8'h01);
    check("t3_int_nest", int_out, 1);
    exp_q.push_back(8'h40);
    pulse(1'b1);
    check("t3_isr_eoi_set", isr, 8'h01);
    pulse(1'b0);
    check("t3_isr", isr, 8'h01);
    check("t3_int_blk", int_out, 0);
    do_eoi();
    cyc(1);
    check("t3_int6", int_out, 1);
    exp_q.push_back(8'h46);
    pulse(1'b0);
    pulse(1'b0);
    check("t3_isr6", isr, 8'h40);
    do_eoi();
    cyc(1);

    // Level-mode request withdrawn before acknowledge -> spurious
    ltim = 1'b1;
    ir = 8'h10;
    cyc(2);
    check("t4_int", int_out, 1);
    ir = '0;
    cyc(1);
    check("t4_irr", irr, 8'h00);
    exp_q.push_back(8'h47);
    pulse(1'b0);
    pulse(1'b0);
    check("t4_isr", isr, 8'h00);
    ltim = 1'b0;
    cyc(1);

    // Automatic EOI on IR1
    aeoi = 1'b1;
    raise(8'h02);
    check("t5_int", int_out, 1);
    exp_q.push_back(8'h41);
    pulse(1'b0);
    check("t5_isr_ack1", isr, 8'h02);
    inta_n = 1'b0;
    cyc(2);
    check("t5_isr_ack2", isr, 8'h02);
    inta_n = 1'b1;
    cyc(1);
    check("t5_isr_aeoi", isr, 8'h00);
    cyc(1);
    aeoi = 1'b0;

    // Fully masked, then init_done low
    imr = 8'hFF;
    raise(8'hFF);
    cyc(1);
    check("t5_mask_int", int_out, 0);
    check("t5_mask_irr", irr, 8'hFF);
    imr = 8'h00;
    init_done = 1'b0;
    cyc(2);
    check("t6_init_int", int_out, 0);
    check("t6_init_irr", irr, 8'hFF);
    init_done = 1'b1;
    cyc(2);
    check("t6_init_re", int_out, 1);

    // Reset during ACK2
    exp_q.push_back(8'h40);
    pulse(1'b0);
    inta_n = 1'b0;
    cyc(2);
    check("t7_oe_ack2", vec_oe, 1);
    #1 reset = 1'b1;
    #1;
    check("t7_oe", vec_oe, 0);
    check("t7_vec", vec_out, 0);
    check("t7_isr", isr, 0);
    check("t7_irr", irr, 0);
    check("t7_int", int_out, 0);
    inta_n = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Fresh acknowledge after reset starts from IDLE
    raise(8'h08);
    check("t8_int", int_out, 1);
    exp_q.push_back(8'h43);
    pulse(1'b0);
    pulse(1'b0);
    check("t8_isr", isr, 8'h08);
    cyc(2);

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: ir  in  8  interrupt request lines, IR0 highest priority.
REQ-004 SHALL have ports: ltim  in  1  1 = level-triggered, 0 = edge-triggered (ICW1 bit 3).
REQ-005 SHALL have ports: imr  in  8  mask; bit n = 1 blocks IRn.
REQ-006 SHALL have ports: vec_base  in  5  vector bits T7..T3 (ICW2).
REQ-007 SHALL have ports: aeoi  in  1  automatic EOI mode (ICW4 bit 1).
REQ-008 SHALL have ports: init_done  in  1  initialization complete; 0 holds block idle.
REQ-009 SHALL have ports: eoi  in  1  one-cycle non-specific EOI strobe (OCW2).
REQ-010 SHALL have ports: inta_n  in  1  interrupt acknowledge, active-low, clk-synchronous.
REQ-011 SHALL have ports: int_out  out  1  interrupt request to CPU.
REQ-012 SHALL have ports: irr  out  8  interrupt request register.
REQ-013 SHALL have ports: isr  out  8  in-service register.
REQ-014 SHALL have ports: vec_out  out  8  vector byte {vec_base, sel[2:0]}.
REQ-015 SHALL have ports: vec_oe  out  1  vector drive enable toward data bus.

Function
REQ-016 Edge mode: irr[n] SHALL set on a cycle where ir[n]=1 and ir[n] was 0 the previous cycle; level mode: irr[n] SHALL set while ir[n]=1.
REQ-017 irr[n] SHALL clear when ir[n]=0 in level mode, or when IRn is acknowledged (REQ-021).
REQ-018 Request resolution: pend = irr & ~imr; req = lowest-index set bit of pend; ishi = lowest-index set bit of isr.
REQ-019 int_out SHALL be 1 in IDLE when init_done=1, pend≠0, and (isr=0 or req index < ishi index); otherwise 0; registered, one-cycle latency.
REQ-020 FSM states: IDLE, ACK1, ACK2. An inta_n falling edge is a cycle with inta_n=0 following a cycle with inta_n=1.
REQ-021 IDLE -> ACK1 on inta_n falling edge: latch sel=req; set isr[sel]; clear irr[sel] in edge mode; int_out=0.
REQ-022 Spurious: if pend=0 at the first falling edge, sel SHALL be 7 and isr SHALL NOT change.
REQ-023 ACK1 -> ACK2 on the second inta_n falling edge; vec_out={vec_base, sel} and vec_oe=1 while in ACK2 and inta_n=0.
REQ-024 ACK2 -> IDLE on inta_n rising edge; if aeoi=1 and not spurious, clear isr[sel] in the same cycle.
REQ-025 eoi=1 SHALL clear the lowest-index set bit of isr; no effect if isr=0; allowed in any state.
REQ-026 eoi coinciding with an ISR set in the same cycle SHALL clear the previous highest bit before the new bit is set (new bit survives).
REQ-027 New ir edges SHALL be captured into irr in every state, including ACK1/ACK2.
REQ-028 imr changes SHALL NOT affect sel once latched.
REQ-029 init_done=0 SHALL force the FSM to IDLE and int_out=0; irr/isr are preserved.

Reset
REQ-030 reset=1 SHALL asynchronously set irr=0, isr=0, int_out=0, vec_out=0, vec_oe=0, sel=0, FSM=IDLE, previous-ir and previous-inta_n samples to 0 and 1.
REQ-031 reset asserted mid-acknowledge (ACK1/ACK2) SHALL abort the cycle with no ISR retained.

Verification
REQ-032 vec_base=5'b01000, imr=0, edge mode, pulse ir[3] -> int_out=1 next cycle; two inta_n pulses -> isr=8'h08, irr=0, vec_out=8'h43 with vec_oe=1 during the 2nd pulse.
REQ-033 ir[5] and ir[2] rise together -> first ack selects IR2 (vec_out=base|2); after eoi, int_out reasserts, and the next ack selects IR5.
REQ-034 isr=8'h04 in service, ir[6] rises -> int_out stays 0; ir[0] rises -> int_out=1 (nesting).
REQ-035 Request for ir[4] withdrawn in level mode before the first inta_n -> vec_out=base|7, isr unchanged (spurious).
REQ-036 aeoi=1, ack IR1 -> isr=0 after the inta_n rising edge of the 2nd pulse; imr=8'hFF with ir active -> int_out stays 0.
REQ-037 reset asserted during ACK2 -> vec_oe=0, isr=0, FSM=IDLE immediately, without waiting for a clk edge.
